// File: rtl/serial_alu_if.sv
// Request/response bundle for the digit-serial ALU.
// master drives requests; slave is the ALU side.
interface serial_alu_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             zero;
   logic             neg;
   logic             illegal;

   modport master (
      output in_valid, op, a_in, b_in,
      input  in_ready, out, out_valid, zero, neg, illegal
   );

   modport slave (
      input  in_valid, op, a_in, b_in,
      output in_ready, out, out_valid, zero, neg, illegal
   );
endinterface

// File: rtl/serial_alu.sv
// Digit-serial ALU: add/sub/logic/compare DIGIT bits per cycle, shifts one bit per cycle.
// Define SERIAL_ALU_MUL_EN to build the shift-add multiplier for op 10.
module serial_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 8
) (
   input logic         clk,
   input logic         rst_n,
   serial_alu_if.slave bus
);
   localparam int unsigned NDig = WIDTH / DIGIT;
   localparam int unsigned ShW  = $clog2(WIDTH);
   localparam int unsigned CntW = ShW + 1;

   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpSub  = 4'd1;
   localparam logic [3:0] OpAnd  = 4'd2;
   localparam logic [3:0] OpOr   = 4'd3;
   localparam logic [3:0] OpXor  = 4'd4;
   localparam logic [3:0] OpSlt  = 4'd5;
   localparam logic [3:0] OpSltu = 4'd6;
   localparam logic [3:0] OpSll  = 4'd7;
   localparam logic [3:0] OpSrl  = 4'd8;
   localparam logic [3:0] OpSra  = 4'd9;
   localparam logic [3:0] OpMul  = 4'd10;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            r_state, w_state_nxt;
   logic [3:0]        r_op;
   logic [WIDTH-1:0]  r_a, r_b, r_acc, r_out;
   logic              r_carry, r_zero, r_neg, r_illegal, r_illegal_op;
   logic [CntW-1:0]   r_left;

   logic              w_in_ready, w_accept, w_last, w_op_illegal, w_is_sub;
   logic [CntW-1:0]   w_steps;
   logic [ShW-1:0]    w_shamt;
   logic [DIGIT-1:0]  w_a_dig, w_b_dig, w_b_eff, w_dig;
   logic [DIGIT:0]    w_sum;
   logic              w_ovf;
   logic [WIDTH+DIGIT-1:0] w_acc_cat;
   logic [WIDTH-1:0]  w_acc_nxt, w_a_nxt, w_b_nxt, w_result;

   assign w_in_ready = (r_state != StRun);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_last     = (r_left == CntW'(1));
   assign w_shamt    = bus.b_in[ShW-1:0];

   always_comb begin
`ifdef SERIAL_ALU_MUL_EN
      w_op_illegal = (bus.op > OpMul);
`else
      w_op_illegal = (bus.op >= OpMul);
`endif
   end

   always_comb begin
      w_steps = CntW'(1);
      if (!w_op_illegal) begin
         case (bus.op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt, OpSltu: w_steps = CntW'(NDig);
            OpSll, OpSrl, OpSra: w_steps = (w_shamt == '0) ? CntW'(1) : CntW'(w_shamt);
            OpMul:               w_steps = CntW'(WIDTH);
            default:             w_steps = CntW'(1);
         endcase
      end
   end

   // Subtract-class ops feed ~B into the digit adder with carry seeded to 1.
   assign w_is_sub = (r_op == OpSub) || (r_op == OpSlt) || (r_op == OpSltu);
   assign w_a_dig  = r_a[DIGIT-1:0];
   assign w_b_dig  = r_b[DIGIT-1:0];
   assign w_b_eff  = w_is_sub ? ~w_b_dig : w_b_dig;
   assign w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {{DIGIT{1'b0}}, r_carry};
   // On the final digit the low digit holds the operand MSBs.
   assign w_ovf    = (w_a_dig[DIGIT-1] != w_b_dig[DIGIT-1]) &&
                     (w_sum[DIGIT-1] != w_a_dig[DIGIT-1]);

   always_comb begin
      w_dig     = '0;
      w_a_nxt   = r_a;
      w_b_nxt   = r_b;
      w_acc_cat = '0;
      w_acc_nxt = r_acc;
      case (r_op)
         OpAdd, OpSub, OpSlt, OpSltu, OpAnd, OpOr, OpXor: begin
            case (r_op)
               OpAnd:   w_dig = w_a_dig & w_b_dig;
               OpOr:    w_dig = w_a_dig | w_b_dig;
               OpXor:   w_dig = w_a_dig ^ w_b_dig;
               default: w_dig = w_sum[DIGIT-1:0];
            endcase
            w_acc_cat = {w_dig, r_acc};
            w_acc_nxt = w_acc_cat[WIDTH+DIGIT-1:DIGIT];
            w_a_nxt   = r_a >> DIGIT;
            w_b_nxt   = r_b >> DIGIT;
         end
         OpSll: if (r_b[ShW-1:0] != '0) w_acc_nxt = r_acc << 1;
         OpSrl: if (r_b[ShW-1:0] != '0) w_acc_nxt = r_acc >> 1;
         OpSra: if (r_b[ShW-1:0] != '0) w_acc_nxt = {r_a[WIDTH-1], r_acc[WIDTH-1:1]};
`ifdef SERIAL_ALU_MUL_EN
         OpMul: begin
            if (r_b[0]) w_acc_nxt = r_acc + r_a;
            w_a_nxt = r_a << 1;
            w_b_nxt = r_b >> 1;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_result = w_acc_nxt;
      if (r_illegal_op) begin
         w_result = '0;
      end else if (r_op == OpSlt) begin
         w_result = {{(WIDTH-1){1'b0}}, w_sum[DIGIT-1] ^ w_ovf};
      end else if (r_op == OpSltu) begin
         w_result = {{(WIDTH-1){1'b0}}, ~w_sum[DIGIT]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_accept) w_state_nxt = StRun;
         StRun:   if (w_last) w_state_nxt = StDone;
         StDone:  w_state_nxt = w_accept ? StRun : StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_acc        <= '0;
         r_carry      <= 1'b0;
         r_left       <= '0;
         r_illegal_op <= 1'b0;
         r_out        <= '0;
         r_zero       <= 1'b0;
         r_neg        <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op         <= bus.op;
            r_a          <= bus.a_in;
            r_b          <= bus.b_in;
            r_acc        <= (bus.op == OpSll || bus.op == OpSrl || bus.op == OpSra) ?
                            bus.a_in : '0;
            r_carry      <= (bus.op == OpSub || bus.op == OpSlt || bus.op == OpSltu);
            r_left       <= w_steps;
            r_illegal_op <= w_op_illegal;
         end else if (r_state == StRun) begin
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_carry <= w_sum[DIGIT];
            r_left  <= r_left - CntW'(1);
            if (w_last) begin
               r_out     <= w_result;
               r_zero    <= (w_result == '0);
               r_neg     <= w_result[WIDTH-1];
               r_illegal <= r_illegal_op;
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == StDone);
   assign bus.out       = r_out;
   assign bus.zero      = r_zero;
   assign bus.neg       = r_neg;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: driver queues expected results, monitor checks each pulse.
module tb_serial_alu;
   localparam int unsigned W = 32;
   localparam int unsigned D = 8;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   typedef struct {
      string      name;
      logic [W-1:0] out;
      logic       z;
      logic       n;
      logic       ill;
      int         k;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_alu_if #(.WIDTH(W)) bus ();

   serial_alu #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_out, input logic ill,
                        input int k, input bit push);
      exp_t e;
      int   w;
      bus.op       = op;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         chk({name, " accept timeout"}, W'(bus.in_ready), W'(1));
      end else begin
         e.name = name;
         e.out  = exp_out;
         e.z    = (exp_out == '0);
         e.n    = exp_out[W-1];
         e.ill  = ill;
         e.k    = k;
         e.acc  = cyc + 1;
         if (push) q.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) begin
         chk("drain outstanding results", W'(q.size()), W'(0));
         q.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected out_valid: got out 0x%h, required no pulse", bus.out);
         end else begin
            e = q.pop_front();
            chk({e.name, " out"}, bus.out, e.out);
            chk({e.name, " zero"}, W'(bus.zero), W'(e.z));
            chk({e.name, " neg"}, W'(bus.neg), W'(e.n));
            chk({e.name, " illegal"}, W'(bus.illegal), W'(e.ill));
            chk({e.name, " latency"}, W'(cyc - e.acc), W'(e.k));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.op       = '0;
      bus.a_in     = '0;
      bus.b_in     = '0;
      repeat (2) @(negedge clk);
      chk("reset in_ready", W'(bus.in_ready), W'(1));
      chk("reset out_valid", W'(bus.out_valid), W'(0));
      chk("reset out", bus.out, W'(0));
      chk("reset zero", W'(bus.zero), W'(0));
      chk("reset neg", W'(bus.neg), W'(0));
      chk("reset illegal", W'(bus.illegal), W'(0));
      rst_n = 1'b1;
      @(negedge clk);

      issue("ADD ff+1", OP_ADD, 32'h0000_00FF, 32'h1, 32'h0000_0100, 1'b0, 4, 1'b1);
      issue("SUB 5-7", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 4, 1'b1);
      issue("SLT min<1", OP_SLT, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 4, 1'b1);
      issue("SLTU min<1", OP_SLTU, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 4, 1'b1);
      issue("SLT 1<min", OP_SLT, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 4, 1'b1);
      issue("SLTU -1<1", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 4, 1'b1);
      issue("SUB 9-9", OP_SUB, 32'd9, 32'd9, 32'h0, 1'b0, 4, 1'b1);
      issue("AND", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 4, 1'b1);
      issue("OR", OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 4, 1'b1);
      issue("SRA 4", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4, 1'b1);
      issue("SLL shamt0", OP_SLL, 32'h0000_1234, 32'd32, 32'h0000_1234, 1'b0, 1, 1'b1);
      issue("SRL 31", OP_SRL, 32'hF000_0000, 32'd31, 32'h1, 1'b0, 31, 1'b1);
      issue("SLL 3", OP_SLL, 32'h1, 32'd3, 32'h8, 1'b0, 3, 1'b1);
      drain();

      // Back-to-back: XOR request is held through the ADD's RUN phase.
      issue("B2B ADD 1+2", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 4, 1'b1);
      chk("in_ready during RUN", W'(bus.in_ready), W'(0));
      issue("B2B XOR", OP_XOR, 32'hFF, 32'h0F, 32'hF0, 1'b0, 4, 1'b1);
      drain();

`ifdef SERIAL_ALU_MUL_EN
      issue("MUL", OP_MUL, 32'h1234, 32'h10, 32'h0001_2340, 1'b0, 32, 1'b1);
`else
      issue("MUL disabled", OP_MUL, 32'h1234, 32'h10, 32'h0, 1'b1, 1, 1'b1);
`endif
      issue("op13", 4'd13, 32'h1234, 32'h10, 32'h0, 1'b1, 1, 1'b1);
      issue("ADD after illegal", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 4, 1'b1);
      drain();

      // Abort an ADD in its second RUN step; it must never complete.
      issue("ABORT ADD", OP_ADD, 32'd5, 32'd5, 32'd10, 1'b0, 4, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort out_valid", W'(bus.out_valid), W'(0));
      chk("abort in_ready", W'(bus.in_ready), W'(1));
      chk("abort out", bus.out, W'(0));
      chk("abort illegal", W'(bus.illegal), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      issue("ADD 2+2 after reset", OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 4, 1'b1);
      drain();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
